// File: rtl/tx_pkt_scheduler.sv
// Packet scheduler for the 802.11a TX user-data path: gap, payload burst, PHY-done handshake.
// Define USER_PRBS_PAYLOAD_EN to send a PRBS-15 payload instead of the byte-index counter.
module tx_pkt_scheduler #(
    parameter int unsigned LEN_MAX     = 4091,
    parameter int unsigned CRC_BYTES   = 4,
    parameter int unsigned TIMEOUT_CYC = 65535
) (
    input  logic        clk_User,
    input  logic        reset,
    input  logic        cfg_en,
    input  logic [15:0] cfg_len,
    input  logic [15:0] cfg_gap,
    input  logic [15:0] cfg_num_pkts,
    input  logic        phy_tx_done,
    output logic        user_tx_data_start,
    output logic        user_tx_data_end,
    output logic [15:0] packetlength,
    output logic        user_tx_data_valid,
    output logic [7:0]  user_tx_data,
    output logic        sched_busy,
    output logic        sched_done,
    output logic        timeout_err,
    output logic [15:0] pkt_sent_cnt
);

    localparam int unsigned CNT_W = 16;

    typedef enum logic [1:0] {IDLE, GAP, DATA, WAIT_DONE} state_t;

    state_t           state;
    logic [CNT_W-1:0] gap_cnt;
    logic [CNT_W-1:0] len_q;
    logic [CNT_W-1:0] idx;
    logic [CNT_W-1:0] wait_cnt;

    logic [CNT_W-1:0] len_c;
    logic [CNT_W-1:0] gap_c;
    logic [CNT_W-1:0] idx_nxt_c;
    logic [CNT_W-1:0] cnt_inc_c;
    logic [7:0]       first_byte_c;
    logic [7:0]       next_byte_c;

    // Length clamp to 1..LEN_MAX, gap floor of one cycle
    always_comb begin
        len_c = cfg_len;
        if (cfg_len == '0)
            len_c = CNT_W'(1);
        else if (cfg_len > CNT_W'(LEN_MAX))
            len_c = CNT_W'(LEN_MAX);
        gap_c     = (cfg_gap == '0) ? CNT_W'(1) : cfg_gap;
        idx_nxt_c = idx + CNT_W'(1);
        cnt_inc_c = pkt_sent_cnt + CNT_W'(1);
    end

`ifdef USER_PRBS_PAYLOAD_EN
    logic [14:0] prbs_q;
    logic [14:0] prbs_first_c;
    logic [14:0] prbs_nxt_c;

    // x^15 + x^14 + 1, advanced eight bits per payload byte
    function automatic logic [14:0] prbs_step8(input logic [14:0] s);
        logic [14:0] r;
        r = s;
        for (int i = 0; i < 8; i++)
            r = {r[13:0], r[14] ^ r[13]};
        return r;
    endfunction

    always_comb begin
        prbs_first_c = prbs_step8(15'h7FFF);
        prbs_nxt_c   = prbs_step8(prbs_q);
        first_byte_c = prbs_first_c[7:0];
        next_byte_c  = prbs_nxt_c[7:0];
    end

    always_ff @(posedge clk_User) begin
        if (reset)
            prbs_q <= '0;
        else if (state == GAP && cfg_en && gap_cnt == CNT_W'(1))
            prbs_q <= prbs_first_c;
        else if (state == DATA && idx != len_q - CNT_W'(1))
            prbs_q <= prbs_nxt_c;
    end
`else
    always_comb begin
        first_byte_c = 8'h00;
        next_byte_c  = idx_nxt_c[7:0];
    end
`endif

    // Scheduler FSM; every output is a register updated alongside the state
    always_ff @(posedge clk_User) begin
        if (reset) begin
            state              <= IDLE;
            gap_cnt            <= '0;
            len_q              <= '0;
            idx                <= '0;
            wait_cnt           <= '0;
            user_tx_data_start <= 1'b0;
            user_tx_data_end   <= 1'b0;
            packetlength       <= '0;
            user_tx_data_valid <= 1'b0;
            user_tx_data       <= '0;
            sched_busy         <= 1'b0;
            sched_done         <= 1'b0;
            timeout_err        <= 1'b0;
            pkt_sent_cnt       <= '0;
        end else begin
            user_tx_data_start <= 1'b0;
            user_tx_data_end   <= 1'b0;
            sched_done         <= 1'b0;
            timeout_err        <= 1'b0;
            case (state)
                IDLE: begin
                    if (cfg_en) begin
                        state        <= GAP;
                        gap_cnt      <= gap_c;
                        pkt_sent_cnt <= '0;
                        sched_busy   <= 1'b1;
                    end
                end
                GAP: begin
                    if (!cfg_en) begin
                        state      <= IDLE;
                        sched_busy <= 1'b0;
                    end else if (gap_cnt == CNT_W'(1)) begin
                        state              <= DATA;
                        len_q              <= len_c;
                        idx                <= '0;
                        packetlength       <= len_c + CNT_W'(CRC_BYTES);
                        user_tx_data_valid <= 1'b1;
                        user_tx_data_start <= 1'b1;
                        user_tx_data_end   <= (len_c == CNT_W'(1));
                        user_tx_data       <= first_byte_c;
                    end else begin
                        gap_cnt <= gap_cnt - CNT_W'(1);
                    end
                end
                DATA: begin
                    if (idx == len_q - CNT_W'(1)) begin
                        state              <= WAIT_DONE;
                        wait_cnt           <= '0;
                        user_tx_data_valid <= 1'b0;
                    end else begin
                        idx              <= idx_nxt_c;
                        user_tx_data     <= next_byte_c;
                        user_tx_data_end <= (idx_nxt_c == len_q - CNT_W'(1));
                    end
                end
                WAIT_DONE: begin
                    wait_cnt <= wait_cnt + CNT_W'(1);
                    if (phy_tx_done) begin
                        pkt_sent_cnt <= cnt_inc_c;
                        if (cfg_num_pkts != '0 && cnt_inc_c == cfg_num_pkts) begin
                            sched_done <= 1'b1;
                            state      <= IDLE;
                            sched_busy <= 1'b0;
                        end else if (!cfg_en) begin
                            state      <= IDLE;
                            sched_busy <= 1'b0;
                        end else begin
                            state   <= GAP;
                            gap_cnt <= gap_c;
                        end
                    end else if (wait_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                        timeout_err <= 1'b1;
                        if (!cfg_en) begin
                            state      <= IDLE;
                            sched_busy <= 1'b0;
                        end else begin
                            state   <= GAP;
                            gap_cnt <= gap_c;
                        end
                    end
                end
                default: begin
                    state      <= IDLE;
                    sched_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tx_pkt_scheduler.sv
// Scoreboard bench for tx_pkt_scheduler: expected bytes queued at stimulus, popped per valid byte.
module tb_tx_pkt_scheduler;

    localparam int unsigned LEN_MAX   = 4091;
    localparam int unsigned CRC_BYTES = 4;
    localparam int unsigned TMO       = 100;

    typedef struct packed {
        logic [15:0] pl;
        logic        s;
        logic        e;
        logic [7:0]  d;
    } exp_t;

    logic        clk_User = 1'b0;
    logic        reset    = 1'b1;
    logic        cfg_en   = 1'b0;
    logic [15:0] cfg_len  = '0;
    logic [15:0] cfg_gap  = '0;
    logic [15:0] cfg_num_pkts = '0;
    logic        phy_tx_done  = 1'b0;
    logic        user_tx_data_start;
    logic        user_tx_data_end;
    logic [15:0] packetlength;
    logic        user_tx_data_valid;
    logic [7:0]  user_tx_data;
    logic        sched_busy;
    logic        sched_done;
    logic        timeout_err;
    logic [15:0] pkt_sent_cnt;

    tx_pkt_scheduler #(.LEN_MAX(LEN_MAX), .CRC_BYTES(CRC_BYTES), .TIMEOUT_CYC(TMO)) dut (
        .clk_User(clk_User), .reset(reset), .cfg_en(cfg_en), .cfg_len(cfg_len),
        .cfg_gap(cfg_gap), .cfg_num_pkts(cfg_num_pkts), .phy_tx_done(phy_tx_done),
        .user_tx_data_start(user_tx_data_start), .user_tx_data_end(user_tx_data_end),
        .packetlength(packetlength), .user_tx_data_valid(user_tx_data_valid),
        .user_tx_data(user_tx_data), .sched_busy(sched_busy), .sched_done(sched_done),
        .timeout_err(timeout_err), .pkt_sent_cnt(pkt_sent_cnt)
    );

    always #5 clk_User = ~clk_User;

    int   n_total = 0;
    int   n_bad   = 0;
    int   cyc     = 0;
    int   n_start = 0, n_end = 0, n_done = 0, n_tmo = 0;
    int   last_start_cyc = 0, last_end_cyc = 0, last_tmo_cyc = 0;
    bit   sb_off  = 1'b0;
    exp_t exp_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h at cyc=%0d", tag, got, exp, cyc);
        end
    endtask

    // Reference payload for one packet, derived independently of the DUT
    task automatic push_pkt(input int len);
        int          lq;
        logic [14:0] s;
        logic [7:0]  d;
        exp_t        x;
        lq = (len == 0) ? 1 : (len > int'(LEN_MAX)) ? int'(LEN_MAX) : len;
        s  = 15'h7FFF;
        for (int i = 0; i < lq; i++) begin
`ifdef USER_PRBS_PAYLOAD_EN
            for (int b = 0; b < 8; b++) s = {s[13:0], s[14] ^ s[13]};
            d = s[7:0];
`else
            d = 8'(i % 256);
`endif
            x.pl = 16'(lq + int'(CRC_BYTES));
            x.s  = (i == 0);
            x.e  = (i == lq - 1);
            x.d  = d;
            exp_q.push_back(x);
        end
    endtask

    always @(posedge clk_User) cyc <= cyc + 1;

    // Output monitor: pops one expected byte per valid cycle
    always @(negedge clk_User) begin
        exp_t e;
        if ((user_tx_data_start || user_tx_data_end) && !user_tx_data_valid)
            chk("ctl_without_valid", 32'd0, 32'd1);
        if (user_tx_data_valid && !sb_off) begin
            if (exp_q.size() == 0) begin
                chk("extra_valid", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("data", 32'(user_tx_data), 32'(e.d));
                chk("start", 32'(user_tx_data_start), 32'(e.s));
                chk("end", 32'(user_tx_data_end), 32'(e.e));
                chk("pktlen", 32'(packetlength), 32'(e.pl));
            end
        end
        if (user_tx_data_start) begin n_start++; last_start_cyc = cyc; end
        if (user_tx_data_end)   begin n_end++;   last_end_cyc   = cyc; end
        if (sched_done)         n_done++;
        if (timeout_err)        begin n_tmo++; last_tmo_cyc = cyc; end
    end

    task automatic tick();
        @(negedge clk_User);
        #1;
    endtask

    task automatic wait_starts(input int target, input int budget);
        int b = budget;
        while (n_start < target && b > 0) begin tick(); b--; end
        if (n_start < target) chk("wait_start", 32'(n_start), 32'(target));
    endtask

    task automatic wait_ends(input int target, input int budget);
        int b = budget;
        while (n_end < target && b > 0) begin tick(); b--; end
        if (n_end < target) chk("wait_end", 32'(n_end), 32'(target));
    endtask

    task automatic pulse_done();
        phy_tx_done = 1'b1;
        tick();
        phy_tx_done = 1'b0;
    endtask

    task automatic run_single(input int len);
        int s0 = n_start;
        int e0 = n_end;
        cfg_len = 16'(len); cfg_gap = 16'd1; cfg_num_pkts = 16'd1;
        push_pkt(len);
        cfg_en = 1'b1;
        wait_starts(s0 + 1, 20);
        cfg_en = 1'b0;
        wait_ends(e0 + 1, 5000);
        repeat (3) tick();
        pulse_done();
        chk("single_done", 32'(sched_done), 32'd1);
        chk("single_cnt", 32'(pkt_sent_cnt), 32'd1);
        chk("single_busy", 32'(sched_busy), 32'd0);
        tick();
        chk("single_done_pulse", 32'(sched_done), 32'd0);
        chk("single_q_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int t0, s0, e0, d0, k0, e1, e2;
        // Reset state
        repeat (3) tick();
        chk("rst_valid", 32'(user_tx_data_valid), 32'd0);
        chk("rst_start", 32'(user_tx_data_start), 32'd0);
        chk("rst_pl", 32'(packetlength), 32'd0);
        chk("rst_busy", 32'(sched_busy), 32'd0);
        chk("rst_cnt", 32'(pkt_sent_cnt), 32'd0);
        chk("rst_flags", 32'({sched_done, timeout_err, user_tx_data_end}), 32'd0);
        reset = 1'b0;
        tick();

        // Single 150-byte packet with exact cycle timing
        cfg_len = 16'd150; cfg_gap = 16'd3; cfg_num_pkts = 16'd1;
        push_pkt(150);
        d0 = n_done;
        cfg_en = 1'b1;
        t0 = cyc;
        tick();
        chk("t1_busy", 32'(sched_busy), 32'd1);
        wait_starts(1, 20);
        chk("t1_start_cyc", 32'(last_start_cyc - t0), 32'd4);
        cfg_en = 1'b0;
        wait_ends(1, 400);
        chk("t1_end_cyc", 32'(last_end_cyc - t0), 32'd153);
        tick();
        chk("t1_valid_low", 32'(user_tx_data_valid), 32'd0);
        chk("t1_wait_busy", 32'(sched_busy), 32'd1);
        while (cyc < t0 + 200) tick();
        pulse_done();
        chk("t1_cnt", 32'(pkt_sent_cnt), 32'd1);
        chk("t1_done", 32'(sched_done), 32'd1);
        chk("t1_idle", 32'(sched_busy), 32'd0);
        chk("t1_ndone", 32'(n_done - d0), 32'd1);

        // Length boundaries
        run_single(1);
        run_single(0);
        run_single(5000);

        // Continuous run, byte wrap at 256, no sched_done
        cfg_len = 16'd300; cfg_gap = 16'd2; cfg_num_pkts = 16'd0;
        for (int p = 0; p < 3; p++) push_pkt(300);
        s0 = n_start; e0 = n_end; d0 = n_done;
        cfg_en = 1'b1;
        for (int p = 0; p < 3; p++) begin
            if (p == 2) begin
                wait_starts(s0 + 3, 400);
                cfg_en = 1'b0;
            end
            wait_ends(e0 + p + 1, 800);
            repeat (9) tick();
            pulse_done();
            chk("cont_cnt", 32'(pkt_sent_cnt), 32'(p + 1));
            chk("cont_no_done", 32'(sched_done), 32'd0);
        end
        chk("cont_idle", 32'(sched_busy), 32'd0);
        chk("cont_ndone", 32'(n_done - d0), 32'd0);
        chk("cont_q_empty", 32'(exp_q.size()), 32'd0);

        // Timeout, restart after gap, then done coinciding with timeout
        cfg_len = 16'd4; cfg_gap = 16'd2; cfg_num_pkts = 16'd0;
        push_pkt(4); push_pkt(4);
        s0 = n_start; e0 = n_end; k0 = n_tmo;
        cfg_en = 1'b1;
        wait_ends(e0 + 1, 50);
        e1 = last_end_cyc;
        wait_starts(s0 + 2, 300);
        chk("tmo_seen", 32'(n_tmo - k0), 32'd1);
        chk("tmo_delay", 32'(last_tmo_cyc - e1), 32'd101);
        chk("tmo_restart", 32'(last_start_cyc - last_tmo_cyc), 32'd2);
        chk("tmo_cnt", 32'(pkt_sent_cnt), 32'd0);
        cfg_en = 1'b0;
        wait_ends(e0 + 2, 50);
        e2 = last_end_cyc;
        while (cyc < e2 + 100) tick();
        pulse_done();
        chk("tie_cnt", 32'(pkt_sent_cnt), 32'd1);
        chk("tie_no_err", 32'(timeout_err), 32'd0);
        chk("tie_idle", 32'(sched_busy), 32'd0);
        repeat (3) tick();
        chk("tie_ntmo", 32'(n_tmo - k0), 32'd1);

        // phy_tx_done ignored in GAP and DATA; cfg_en dropped mid-DATA
        cfg_len = 16'd20; cfg_gap = 16'd5; cfg_num_pkts = 16'd0;
        push_pkt(20);
        s0 = n_start; e0 = n_end; d0 = n_done;
        cfg_en = 1'b1;
        tick(); tick();
        pulse_done();
        chk("gap_ign_cnt", 32'(pkt_sent_cnt), 32'd0);
        chk("gap_ign_busy", 32'(sched_busy), 32'd1);
        wait_starts(s0 + 1, 20);
        pulse_done();
        chk("data_ign_cnt", 32'(pkt_sent_cnt), 32'd0);
        cfg_en = 1'b0;
        wait_ends(e0 + 1, 50);
        repeat (5) tick();
        chk("wait_busy", 32'(sched_busy), 32'd1);
        pulse_done();
        chk("drop_cnt", 32'(pkt_sent_cnt), 32'd1);
        chk("drop_idle", 32'(sched_busy), 32'd0);
        chk("drop_ndone", 32'(n_done - d0), 32'd0);

        // cfg_en dropped in GAP aborts without a packet
        cfg_gap = 16'd10;
        s0 = n_start;
        cfg_en = 1'b1;
        repeat (3) tick();
        cfg_en = 1'b0;
        repeat (2) tick();
        chk("gap_abort_idle", 32'(sched_busy), 32'd0);
        repeat (15) tick();
        chk("gap_abort_nostart", 32'(n_start), 32'(s0));

        // Reset in the middle of a packet
        sb_off = 1'b1;
        cfg_len = 16'd50; cfg_gap = 16'd1;
        s0 = n_start; e0 = n_end;
        cfg_en = 1'b1;
        wait_starts(s0 + 1, 20);
        cfg_en = 1'b0;
        repeat (5) tick();
        reset = 1'b1;
        tick();
        chk("mid_rst_valid", 32'(user_tx_data_valid), 32'd0);
        chk("mid_rst_busy", 32'(sched_busy), 32'd0);
        chk("mid_rst_pl", 32'(packetlength), 32'd0);
        chk("mid_rst_data", 32'(user_tx_data), 32'd0);
        chk("mid_rst_cnt", 32'(pkt_sent_cnt), 32'd0);
        reset = 1'b0;
        repeat (3) tick();
        chk("mid_rst_no_end", 32'(n_end), 32'(e0));
        sb_off = 1'b0;
        chk("final_q_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
